controller_poller_m: RTL and testbench

CONTROLLER_POLLER_M -- requirements
Module: controller_poller_m

---
 rtl/controller_pkg.sv | 18 +
 rtl/controller_channel_m.sv | 42 ++++
 rtl/controller_poller_m.sv | 97 +++++++++
 tb/tb_controller_poller_m.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// Shared types and limits for the serial game-pad poller.
package controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } state_t;

    localparam int MAX_CONTROLLERS = 4;
    localparam int MAX_BUTTONS     = 16;
    localparam int MAX_DIV         = 255;
    localparam int PHASE_W         = $clog2(MAX_DIV + 1);
    localparam int BIT_W           = $clog2(MAX_BUTTONS + 1);

endpackage

// File: rtl/controller_channel_m.sv
// One pad: MSB-first shift register, held state and edge detection.
module controller_channel_m #(
    parameter int NUM_BUTTONS = 8
) (
    input  logic                   clk_1,
    input  logic                   rst_B,
    input  logic                   clear,
    input  logic                   shift,
    input  logic                   load,
    input  logic                   data_B,
    output logic [NUM_BUTTONS-1:0] buttons,
    output logic [NUM_BUTTONS-1:0] pressed,
    output logic [NUM_BUTTONS-1:0] released
);

    logic [NUM_BUTTONS-1:0] shreg;
    logic [NUM_BUTTONS-1:0] nxt;

    // Pad data is active-low; the final bit is folded in on the load cycle.
    assign nxt = NUM_BUTTONS'({shreg, ~data_B});

    always_ff @(posedge clk_1) begin
        if (!rst_B) begin
            shreg    <= '0;
            buttons  <= '0;
            pressed  <= '0;
            released <= '0;
        end else begin
            if (clear) begin
                shreg <= '0;
            end else if (shift) begin
                shreg <= nxt;
            end
            if (load) begin
                buttons  <= nxt;
                pressed  <= nxt & ~buttons;
                released <= ~nxt & buttons;
            end
        end
    end

endmodule

// File: rtl/controller_poller_m.sv
// Shared latch/clock sequencer driving NUM_CONTROLLERS pad channels.
module controller_poller_m
    import controller_pkg::*;
#(
    parameter int NUM_CONTROLLERS = 2,
    parameter int NUM_BUTTONS     = 8,
    parameter int CLK_DIV         = 1,
    parameter int LATCH_CYCLES    = 1
) (
    input  logic                                   clk_1,
    input  logic                                   rst_B,
    input  logic                                   start,
    output logic                                   controller_clk,
    output logic                                   controller_latch,
    input  logic [NUM_CONTROLLERS-1:0]             controller_data_B,
    output logic [NUM_CONTROLLERS*NUM_BUTTONS-1:0] buttons_out,
    output logic [NUM_CONTROLLERS*NUM_BUTTONS-1:0] pressed_out,
    output logic [NUM_CONTROLLERS*NUM_BUTTONS-1:0] released_out,
    output logic                                   busy,
    output logic                                   done
);

    localparam logic [PHASE_W-1:0] LAT_LAST  = PHASE_W'(LATCH_CYCLES - 1);
    localparam logic [PHASE_W-1:0] DIV_LAST  = PHASE_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]   BITS_LAST = BIT_W'(NUM_BUTTONS - 1);

    state_t             state;
    state_t             next;
    logic [PHASE_W-1:0] phase;
    logic [BIT_W-1:0]   nbits;
    logic               sample;
    logic               last_bit;

    assign sample   = (state == LOW) && (phase == DIV_LAST);
    assign last_bit = (nbits == BITS_LAST);

    always_ff @(posedge clk_1) begin
        if (!rst_B) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:  if (start) next = LATCH;
            LATCH: if (phase == LAT_LAST) next = LOW;
            LOW:   if (sample) next = last_bit ? DONE : HIGH;
            HIGH:  if (phase == DIV_LAST) next = LOW;
            DONE:  next = IDLE;
            default: next = IDLE;
        endcase
    end

    // phase restarts on every state change so each phase length is exact
    always_ff @(posedge clk_1) begin
        if (!rst_B) begin
            phase <= '0;
            nbits <= '0;
        end else begin
            if (state == IDLE || next != state) begin
                phase <= '0;
            end else begin
                phase <= phase + PHASE_W'(1);
            end
            if (state == LATCH) begin
                nbits <= '0;
            end else if (sample) begin
                nbits <= nbits + BIT_W'(1);
            end
        end
    end

    assign controller_latch = (state == LATCH);
    assign controller_clk   = (state == HIGH);
    assign busy             = (state != IDLE);
    assign done             = (state == DONE);

    for (genvar c = 0; c < NUM_CONTROLLERS; c++) begin : g_ch
        controller_channel_m #(
            .NUM_BUTTONS(NUM_BUTTONS)
        ) u_ch (
            .clk_1   (clk_1),
            .rst_B   (rst_B),
            .clear   (state == LATCH),
            .shift   (sample),
            .load    (sample && last_bit),
            .data_B  (controller_data_B[c]),
            .buttons (buttons_out[c*NUM_BUTTONS +: NUM_BUTTONS]),
            .pressed (pressed_out[c*NUM_BUTTONS +: NUM_BUTTONS]),
            .released(released_out[c*NUM_BUTTONS +: NUM_BUTTONS])
        );
    end

endmodule

// File: tb/tb_controller_poller_m.sv
// Scoreboard bench: default poller plus a 4-pad 12-button divided instance.
module tb_controller_poller_m;

    logic clk_1 = 1'b0;
    always #5 clk_1 = ~clk_1;

    logic        rst_a, rst_b, start_a, start_b;
    logic        cclk_a, latch_a, busy_a, done_a;
    logic        cclk_b, latch_b, busy_b, done_b;
    logic [1:0]  data_a;
    logic [3:0]  data_b;
    logic [15:0] bo_a, po_a, ro_a;
    logic [47:0] bo_b, po_b, ro_b;

    controller_poller_m dut_a (
        .clk_1            (clk_1),
        .rst_B            (rst_a),
        .start            (start_a),
        .controller_clk   (cclk_a),
        .controller_latch (latch_a),
        .controller_data_B(data_a),
        .buttons_out      (bo_a),
        .pressed_out      (po_a),
        .released_out     (ro_a),
        .busy             (busy_a),
        .done             (done_a)
    );

    controller_poller_m #(
        .NUM_CONTROLLERS(4),
        .NUM_BUTTONS    (12),
        .CLK_DIV        (3),
        .LATCH_CYCLES   (2)
    ) dut_b (
        .clk_1            (clk_1),
        .rst_B            (rst_b),
        .start            (start_b),
        .controller_clk   (cclk_b),
        .controller_latch (latch_b),
        .controller_data_B(data_b),
        .buttons_out      (bo_b),
        .pressed_out      (po_b),
        .released_out     (ro_b),
        .busy             (busy_b),
        .done             (done_b)
    );

    typedef struct {
        logic [63:0] b;
        logic [63:0] p;
        logic [63:0] r;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Pad models: parallel load on latch, advance on each shift-clock rise.
    logic [7:0]  pat_a [2];
    logic [11:0] pat_b [4];
    int          ia = 0;
    int          ib = 0;
    logic        pca = 1'b0;
    logic        pcb = 1'b0;

    always @(posedge clk_1) begin
        if (latch_a) ia <= 0;
        else if (cclk_a && !pca) ia <= ia + 1;
        pca <= cclk_a;
        if (latch_b) ib <= 0;
        else if (cclk_b && !pcb) ib <= ib + 1;
        pcb <= cclk_b;
    end

    always_comb begin
        for (int c = 0; c < 2; c++)
            data_a[c] = ~pat_a[c][(ia > 7) ? 0 : 7 - ia];
        for (int c = 0; c < 4; c++)
            data_b[c] = ~pat_b[c][(ib > 11) ? 0 : 11 - ib];
    end

    int bst[2], ecnt[2], hrun[2], lrun[2], irun[2], bcnt[2];
    int ldone[2] = '{-1, -1};
    bit pb[2], pc[2], pl[2], sd[2], b2b[2];

    task automatic mon(input int id, input logic bsy, input logic ck,
                       input logic lt, input logic dn,
                       input logic [63:0] bo, input logic [63:0] po,
                       input logic [63:0] ro, input int lat,
                       input int edges, input int div, input int lcyc);
        exp_t e;
        if (bsy && !pb[id]) begin
            if (b2b[id] && ldone[id] >= 0)
                check($sformatf("idle_gap%0d", id), 64'(irun[id]), 64'd1);
            bst[id]  = cyc;
            ecnt[id] = 0;
            bcnt[id] = 0;
            sd[id]   = 1'b0;
        end
        if (bsy) bcnt[id]++;
        irun[id] = bsy ? 0 : irun[id] + 1;
        if (!bsy && pb[id] && sd[id])
            check($sformatf("busy_len%0d", id), 64'(bcnt[id]), 64'(lat + 1));
        if (ck && !pc[id]) ecnt[id]++;
        if (ck) hrun[id]++;
        if (!ck && pc[id]) begin
            check($sformatf("clk_high%0d", id), 64'(hrun[id]), 64'(div));
            hrun[id] = 0;
        end
        if (lt) lrun[id]++;
        if (!lt && pl[id]) begin
            check($sformatf("latch_len%0d", id), 64'(lrun[id]), 64'(lcyc));
            lrun[id] = 0;
        end
        if (dn) begin
            check($sformatf("latency%0d", id), 64'(cyc - bst[id]), 64'(lat));
            check($sformatf("clk_edges%0d", id), 64'(ecnt[id]), 64'(edges));
            if (b2b[id] && ldone[id] >= 0)
                check($sformatf("period%0d", id), 64'(cyc - ldone[id]),
                      64'(lat + 2));
            ldone[id] = cyc;
            sd[id]    = 1'b1;
            if ((id == 0 ? q_a.size() : q_b.size()) == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done%0d actual=1 required=0", id);
            end else begin
                e = (id == 0) ? q_a.pop_front() : q_b.pop_front();
                check($sformatf("buttons%0d", id), bo, e.b);
                check($sformatf("pressed%0d", id), po, e.p);
                check($sformatf("released%0d", id), ro, e.r);
            end
        end
        pb[id] = bsy;
        pc[id] = ck;
        pl[id] = lt;
    endtask

    always @(negedge clk_1) begin
        cyc++;
        mon(0, busy_a, cclk_a, latch_a, done_a, 64'(bo_a), 64'(po_a),
            64'(ro_a), 16, 7, 1, 1);
        mon(1, busy_b, cclk_b, latch_b, done_b, 64'(bo_b), 64'(po_b),
            64'(ro_b), 71, 11, 3, 2);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_1);
    endtask

    task automatic push_a(input logic [15:0] b, input logic [15:0] p,
                          input logic [15:0] r);
        exp_t e;
        e.b = 64'(b);
        e.p = 64'(p);
        e.r = 64'(r);
        q_a.push_back(e);
    endtask

    task automatic pulse_a();
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
    endtask

    task automatic wait_a(input int maxc);
        int k = 0;
        while ((busy_a || q_a.size() != 0) && k < maxc) begin
            tick(1);
            k++;
        end
        checks++;
        if (k >= maxc) begin
            failures++;
            $display("FAIL timeout_a actual=%0d required=<%0d", k, maxc);
        end
    endtask

    task automatic wait_b(input int maxc);
        int k = 0;
        while ((busy_b || q_b.size() != 0) && k < maxc) begin
            tick(1);
            k++;
        end
        checks++;
        if (k >= maxc) begin
            failures++;
            $display("FAIL timeout_b actual=%0d required=<%0d", k, maxc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        exp_t e;
        rst_a   = 1'b0;
        rst_b   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        pat_a   = '{8'hFE, 8'h7F};
        pat_b   = '{12'hABC, 12'h123, 12'hF0F, 12'h5A5};
        tick(3);
        check("rst_buttons", 64'(bo_a), 64'd0);
        check("rst_pressed", 64'(po_a), 64'd0);
        check("rst_released", 64'(ro_a), 64'd0);
        check("rst_ctrl", {60'd0, busy_a, done_a, cclk_a, latch_a}, 64'd0);
        check("rst_ctrl_b", {60'd0, busy_b, done_b, cclk_b, latch_b}, 64'd0);
        check("rst_buttons_b", 64'(bo_b), 64'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick(2);

        push_a(16'h7FFE, 16'h7FFE, 16'h0000);
        pulse_a();
        wait_a(40);

        e.b = 64'h5A5F0F123ABC;
        e.p = 64'h5A5F0F123ABC;
        e.r = 64'd0;
        q_b.push_back(e);
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        wait_b(120);

        pat_a[0] = 8'hFF;
        push_a(16'h7FFF, 16'h0001, 16'h0000);
        pulse_a();
        wait_a(40);

        push_a(16'h7FFF, 16'h0000, 16'h0000);
        pulse_a();
        tick(5);
        pulse_a();
        wait_a(40);

        pat_a[1] = 8'h00;
        b2b[0]   = 1'b1;
        ldone[0] = -1;
        push_a(16'h00FF, 16'h0000, 16'h7F00);
        push_a(16'h00FF, 16'h0000, 16'h0000);
        push_a(16'h00FF, 16'h0000, 16'h0000);
        start_a = 1'b1;
        tick(40);
        start_a = 1'b0;
        wait_a(80);
        b2b[0] = 1'b0;

        pat_a[0] = 8'hA5;
        pulse_a();
        tick(7);
        rst_a = 1'b0;
        tick(1);
        rst_a = 1'b1;
        check("abort_buttons", 64'(bo_a), 64'd0);
        check("abort_pressed", 64'(po_a), 64'd0);
        check("abort_released", 64'(ro_a), 64'd0);
        check("abort_busy", {63'd0, busy_a}, 64'd0);
        tick(25);
        push_a(16'h00A5, 16'h00A5, 16'h0000);
        pulse_a();
        wait_a(40);

        check("queue_a_empty", 64'(q_a.size()), 64'd0);
        check("queue_b_empty", 64'(q_b.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
